// File: rtl/mul4_pkg.sv
// ---------------------------------------------------------------------------
// mul4_pkg
// Shared definitions for the 4x4 multiplier datapath and its consumers:
//   PROD_W                   width of the multiplier product (8 bits)
//   ST_IDLE/ST_ACCUM/ST_HOLD state encoding of mac_accumulator_4b
//   add_sat_wrap()           accumulator add that either wraps or clamps
// ---------------------------------------------------------------------------
package mul4_pkg;

    localparam int PROD_W = 8;

    // Widest accumulator the shared add function supports.
    localparam int ADD_MAX_W = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Adds b to a as w-bit unsigned values (operands must already fit in w bits).
    // Returns {ovf, sum}: ovf is the carry out of the w-bit add, and sum is
    // either the wrapped result or, when sat is set, clamped to 2^w-1.
    function automatic logic [ADD_MAX_W:0] add_sat_wrap(
        input logic [ADD_MAX_W-1:0] a,
        input logic [ADD_MAX_W-1:0] b,
        input int unsigned          w,
        input logic                 sat
    );
        logic [ADD_MAX_W:0]   full;
        logic [ADD_MAX_W:0]   lim;
        logic                 ovf;
        logic [ADD_MAX_W-1:0] res;
        lim  = ({{ADD_MAX_W{1'b0}}, 1'b1} << w) - {{ADD_MAX_W{1'b0}}, 1'b1};
        full = {1'b0, a} + {1'b0, b};
        ovf  = (full > lim);
        if (!ovf) begin
            res = full[ADD_MAX_W-1:0];
        end else if (sat) begin
            res = lim[ADD_MAX_W-1:0];
        end else begin
            res = full[ADD_MAX_W-1:0] & lim[ADD_MAX_W-1:0];
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/acc_add_sat.sv
// ---------------------------------------------------------------------------
// acc_add_sat
// ACC_W-bit accumulator adder: sum = acc_in + prod, with carry-out flag.
// Build option:
//   `MAC_SATURATE_EN defined   -> sum clamps to 2^ACC_W-1 on overflow
//   `MAC_SATURATE_EN undefined -> sum wraps modulo 2^ACC_W
// Ports:
//   acc_in [ACC_W-1:0]  current accumulator value
//   prod   [PROD_W-1:0] unsigned product to add
//   sum    [ACC_W-1:0]  wrapped or clamped result
//   ovf                 carry out of the ACC_W-bit add
// ---------------------------------------------------------------------------
module acc_add_sat
    import mul4_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

`ifdef MAC_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [ADD_MAX_W:0] res;

    always_comb begin
        res = add_sat_wrap(ADD_MAX_W'(acc_in), ADD_MAX_W'(prod),
                           ACC_W, SAT_EN);
        sum = res[ACC_W-1:0];
        ovf = res[ADD_MAX_W];
    end

    // The upper result bits are always zero for an ACC_W-bit add.
    generate
        if (ACC_W < ADD_MAX_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^res[ADD_MAX_W-1:ACC_W];
        end
    endgenerate

endmodule

// File: rtl/mac_accumulator_4b.sv
// ---------------------------------------------------------------------------
// mac_accumulator_4b
// Accumulates a frame of 8-bit products into an ACC_W-bit sum and presents one
// result per frame over a valid/ready handshake. A frame closes on in_last or
// once MAX_TERMS products have been accepted, whichever comes first.
// Build option: `MAC_SATURATE_EN (honoured in acc_add_sat) selects a clamping
// accumulator instead of a wrapping one.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     product handshake; prod and in_last qualify a beat
//   out_valid/out_ready   result handshake
//   out_sum [ACC_W-1:0]   frame sum
//   out_count [CNT_W-1:0] products in the frame (1..MAX_TERMS)
//   out_ovf               sum overflowed ACC_W bits at some beat of the frame
// ---------------------------------------------------------------------------
module mac_accumulator_4b
    import mul4_pkg::*;
#(
    parameter  int ACC_W     = 16,
    parameter  int MAX_TERMS = 16,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             beat;
    logic [CNT_W-1:0] cnt_inc;

    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_in (acc_q),
        .prod   (prod),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign beat     = in_valid && in_ready;
    // cnt_q < MAX_TERMS while accumulating, so the increment never overflows CNT_W.
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d   = ACC_W'(prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (in_last || (MAX_TERMS == 1)) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d   = add_sum;
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_q | add_ovf;
                    // in_last and the count limit coinciding is still one close.
                    state_d = (in_last || (cnt_inc == MAX_CNT)) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Results come straight from the frame registers, masked to zero outside HOLD.
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_count = out_valid ? cnt_q : '0;
    assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_mac_accumulator_4b.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator_4b
// Directed and random frames against a frame-level model of mac_accumulator_4b
// (ACC_W=9, MAX_TERMS=4). Define MAC_SATURATE_EN to match a clamping build.
// ---------------------------------------------------------------------------
module tb_mac_accumulator_4b;

    localparam int ACC_W     = 9;
    localparam int MAX_TERMS = 4;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);
    localparam int LIM       = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accumulator_4b #(
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame model: the true (unbounded) sum decides everything. The running
    // sum only ever grows, so a carry occurred at some beat exactly when the
    // true total exceeds the ACC_W range.
    function automatic int model_sum(input int total);
`ifdef MAC_SATURATE_EN
        return (total > LIM) ? LIM : total;
`else
        return total % (LIM + 1);
`endif
    endfunction

    // Present one beat and hold it until the DUT takes it; returns at posedge+1.
    task automatic send_beat(input logic [7:0] p, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        prod     = p;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("beat_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        prod     = 8'($urandom);
        $display("beat prod=%0d last=%0b", p, last);
    endtask

    // Check a pending result, stall it for 'hold' cycles (optionally with a
    // product waiting), then complete the handshake and check the outputs clear.
    task automatic take_result(input string tag, input int total, input int n,
                               input int hold, input logic busy);
        int es;
        es = model_sum(total);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"},   out_sum,   es);
        chk({tag, "_count"}, out_count, n);
        chk({tag, "_ovf"},   out_ovf,   (total > LIM) ? 1 : 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = busy;
            prod     = 8'd77;
            in_last  = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_stall_ready"}, in_ready,  0);
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_sum"},   out_sum,   es);
            chk({tag, "_stall_count"}, out_count, n);
        end
        if (!busy) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_sum"},   out_sum,   0);
        chk({tag, "_done_count"}, out_count, 0);
        chk({tag, "_done_ovf"},   out_ovf,   0);
        $display("frame %s sum=%0d count=%0d total=%0d", tag, es, n, total);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int total;
        int len;
        logic [7:0] p;
        logic last;

        // Reset held for 3 cycles.
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; prod = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_valid", out_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum",   out_sum,   0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf",   out_ovf,   0);
        chk("rst_ready", in_ready,  1);
        $display("reset released");

        // 6 + 15 + 225, closed by in_last.
        send_beat(8'd6, 1'b0);
        chk("f1_early_valid", out_valid, 0);
        send_beat(8'd15, 1'b0);
        send_beat(8'd225, 1'b1);
        take_result("f1", 246, 3, 0, 1'b0);

        // Auto-close at MAX_TERMS without in_last.
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (i > 0) chk("f2_early_valid", out_valid, 0);
            send_beat(8'd1, 1'b0);
        end
        take_result("f2", 4, 4, 0, 1'b0);

        // in_last on the MAX_TERMS-th beat: exactly one result.
        for (int i = 0; i < MAX_TERMS; i++) send_beat(8'd2, (i == MAX_TERMS - 1));
        take_result("f3", 8, 4, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("f3_no_double_close", out_valid, 0);

        // Backpressure for 5 cycles with a product waiting; it starts the next frame.
        send_beat(8'd100, 1'b0);
        send_beat(8'd50, 1'b1);
        take_result("f4", 150, 2, 5, 1'b1);
        send_beat(8'd77, 1'b1);
        take_result("f5", 77, 1, 0, 1'b0);

        // Overflow: 3 x 225 = 675 in a 9-bit accumulator.
        send_beat(8'd225, 1'b0);
        send_beat(8'd225, 1'b0);
        send_beat(8'd225, 1'b1);
        take_result("f6", 675, 3, 0, 1'b0);

        // Reset mid-frame aborts it; the next frame starts clean.
        send_beat(8'd200, 1'b0);
        send_beat(8'd200, 1'b0);
        rst = 1'b1;
        #2;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready,  1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_after_valid", out_valid, 0);
        send_beat(8'd9, 1'b1);
        take_result("f7", 9, 1, 0, 1'b0);

        // Random frames with idle gaps and random stalls.
        for (int f = 0; f < 40; f++) begin
            len   = $urandom_range(1, MAX_TERMS);
            total = 0;
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                if (b > 0) chk("rnd_early_valid", out_valid, 0);
                p     = 8'($urandom_range(0, 255));
                last  = (b == len - 1) && ((len < MAX_TERMS) || ($urandom_range(0, 1) == 1));
                total = total + int'(p);
                send_beat(p, last);
            end
            take_result($sformatf("rnd%0d", f), total, len, $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
